// File: rtl/rt_rgu_stream.sv
// rt_rgu_stream: streaming primary-ray generator, raster scan into a 3-stage multiply/add/subtract datapath.
// Define RT_RGU_JITTER_EN to add LFSR sub-pixel jitter to the fractional coordinate bits.
module rt_rgu_stream #(
    parameter int IW = 8,
    parameter int QW = 8,
    parameter int XW = 12,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [XW-1:0]             img_w,
    input  logic [XW-1:0]             img_h,
    input  logic [3*(IW+QW)-1:0]      p00_loc,
    input  logic [3*(IW+QW)-1:0]      delta_u,
    input  logic [3*(IW+QW)-1:0]      delta_v,
    input  logic [3*(IW+QW)-1:0]      cam_center,
    output logic                      busy,
    output logic                      done,
    output logic                      ray_valid,
    input  logic                      ray_ready,
    output logic [3*(IW+QW)-1:0]      ray_origin,
    output logic [3*(IW+QW)-1:0]      ray_dir,
    output logic [XW-1:0]             ray_x,
    output logic [XW-1:0]             ray_y,
    output logic                      ray_last
);
    localparam int W  = IW + QW;
    localparam int CW = XW + QW;
    localparam int PW = W + CW + 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    if (QW > 16 || LFSR_SEED == 16'h0) begin : g_cfg_err
        $error("rt_rgu_stream: QW must be <= 16 and LFSR_SEED non-zero");
    end

    logic [1:0]      state;
    logic [XW-1:0]   w_s, h_s, x, y, x1, y1, x2, y2;
    logic [3*W-1:0]  p00_s, du_s, dv_s, cc_s, pu, pv, sum;
    logic            v1, v2, l1, l2;
    logic [QW-1:0]   fx, fy;
    logic            adv, issue, last_px, zero_start, hs_last;

    assign adv        = !ray_valid || ray_ready;
    assign issue      = state == RUN && adv;
    assign last_px    = x == w_s - 1'b1 && y == h_s - 1'b1;
    assign zero_start = state == IDLE && start && (img_w == '0 || img_h == '0);
    assign hs_last    = state == DRAIN && ray_valid && ray_ready && ray_last;
    assign busy       = state != IDLE || done;

    // Signed delta times unsigned fixed-point coordinate, rescaled by QW and wrapped to W bits.
    function automatic logic [W-1:0] scale(input logic [W-1:0] d, input logic [CW-1:0] c);
        logic signed [PW-1:0] p;
        p = $signed({{(CW+1){d[W-1]}}, d}) * $signed({{(W+1){1'b0}}, c});
        return W'(p >>> QW);
    endfunction

`ifdef RT_RGU_JITTER_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk)
        if (!rst_n)
            lfsr <= LFSR_SEED;
        else if (issue)
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign fx = lfsr[QW-1:0];
    assign fy = lfsr[15 -: QW];
`else
    assign fx = '0;
    assign fy = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
            x     <= '0;
            y     <= '0;
            w_s   <= '0;
            h_s   <= '0;
            p00_s <= '0;
            du_s  <= '0;
            dv_s  <= '0;
            cc_s  <= '0;
        end else begin
            done <= hs_last || zero_start;
            if (state == IDLE && start) begin
                state <= zero_start ? IDLE : RUN;
                x     <= '0;
                y     <= '0;
                w_s   <= img_w;
                h_s   <= img_h;
                p00_s <= p00_loc;
                du_s  <= delta_u;
                dv_s  <= delta_v;
                cc_s  <= cam_center;
            end else if (issue) begin
                state <= last_px ? DRAIN : RUN;
                x     <= x == w_s - 1'b1 ? '0 : x + 1'b1;
                y     <= x == w_s - 1'b1 ? y + 1'b1 : y;
            end else if (hs_last) begin
                state <= IDLE;
            end
        end
    end

    // Whole pipeline moves together; a stalled output freezes every stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {v1, l1, x1, y1, pu, pv} <= '0;
            {v2, l2, x2, y2, sum}    <= '0;
            ray_valid  <= 1'b0;
            ray_last   <= 1'b0;
            ray_x      <= '0;
            ray_y      <= '0;
            ray_dir    <= '0;
            ray_origin <= '0;
        end else if (adv) begin
            v1 <= state == RUN;
            l1 <= last_px;
            x1 <= x;
            y1 <= y;
            v2 <= v1;
            l2 <= l1;
            x2 <= x1;
            y2 <= y1;
            ray_valid  <= v2;
            ray_last   <= v2 && l2;
            ray_x      <= x2;
            ray_y      <= y2;
            ray_origin <= cc_s;
            for (int k = 0; k < 3; k++) begin
                pu[k*W +: W]      <= scale(du_s[k*W +: W], {x, fx});
                pv[k*W +: W]      <= scale(dv_s[k*W +: W], {y, fy});
                sum[k*W +: W]     <= p00_s[k*W +: W] + pu[k*W +: W] + pv[k*W +: W];
                ray_dir[k*W +: W] <= sum[k*W +: W] - cc_s[k*W +: W];
            end
        end
    end
endmodule

// File: tb/tb_rt_rgu_stream.sv
// tb_rt_rgu_stream: directed and randomized frames checked against an arithmetic ray model.
module tb_rt_rgu_stream;
    localparam int W  = 16;
    localparam int XW = 12;
    typedef logic [127:0] ray_t;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, ray_ready = 1'b1;
    logic [XW-1:0]  img_w = '0, img_h = '0;
    logic [3*W-1:0] p00_loc = '0, delta_u = '0, delta_v = '0, cam_center = '0;
    logic busy, done, ray_valid, ray_last;
    logic [3*W-1:0] ray_origin, ray_dir;
    logic [XW-1:0]  ray_x, ray_y;
    int total = 0, bad = 0;
    int cp[3], cu[3], cv[3], cc[3];
    logic [3*W-1:0] first_dir, last_dir;
    logic seen;

    always #5 clk = ~clk;

    rt_rgu_stream dut (
        .clk(clk), .rst_n(rst_n), .start(start), .img_w(img_w), .img_h(img_h),
        .p00_loc(p00_loc), .delta_u(delta_u), .delta_v(delta_v), .cam_center(cam_center),
        .busy(busy), .done(done), .ray_valid(ray_valid), .ray_ready(ray_ready),
        .ray_origin(ray_origin), .ray_dir(ray_dir), .ray_x(ray_x), .ray_y(ray_y),
        .ray_last(ray_last)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input ray_t obs, input ray_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_cam;
        for (int k = 0; k < 3; k++) begin
            p00_loc[k*W +: W]    = W'(cp[k]);
            delta_u[k*W +: W]    = W'(cu[k]);
            delta_v[k*W +: W]    = W'(cv[k]);
            cam_center[k*W +: W] = W'(cc[k]);
        end
    endtask

    task automatic rand_cam;
        for (int k = 0; k < 3; k++) begin
            cp[k] = int'($signed(16'($urandom)));
            cu[k] = int'($signed(16'($urandom)));
            cv[k] = int'($signed(16'($urandom)));
            cc[k] = int'($signed(16'($urandom)));
        end
        apply_cam();
    endtask

    // Direction = p00 + x*du + y*dv - centre, wrapped to W bits; origin = centre.
    function automatic ray_t model(input int x, input int y, input bit last);
        logic [3*W-1:0] d, o;
        for (int k = 0; k < 3; k++) begin
            d[k*W +: W] = W'(cp[k] + cu[k] * x + cv[k] * y - cc[k]);
            o[k*W +: W] = W'(cc[k]);
        end
        return {7'b0, XW'(x), XW'(y), last, d, o};
    endfunction

    function automatic ray_t cur();
        return {7'b0, ray_x, ray_y, ray_last, ray_dir, ray_origin};
    endfunction

    task automatic run_frame(input int w, input int h, input int rmode, input bit perturb, input bit lat);
        ray_t q[$];
        ray_t held, obs;
        int n, cyc, first;
        bit stalled;
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++)
                q.push_back(model(xx, yy, xx == w - 1 && yy == h - 1));
        img_w = XW'(w);
        img_h = XW'(h);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_on", ray_t'(busy), 1);
        n = 0; cyc = 0; first = -1; stalled = 1'b0;
        while (n < w * h && cyc < 1000) begin
            obs = cur();
            if (stalled) chk("hold", obs, held);
            if (ray_valid && first < 0) first = cyc;
            ray_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            if (ray_valid && ray_ready) begin
                chk($sformatf("ray%0d", n), obs, q[n]);
                if (n == 0) first_dir = ray_dir;
                last_dir = ray_dir;
                n++;
            end
            stalled = ray_valid && !ray_ready;
            held = obs;
            start = perturb && cyc == 2;
            if (perturb && cyc == 2) begin
                rand_cam();
                img_w = XW'($urandom);
                img_h = XW'($urandom);
            end
            step();
            cyc++;
        end
        start = 1'b0;
        chk("count", n, w * h);
        if (lat) chk("latency", first, 3);
        chk("done_pulse", {busy, done}, 2'b11);
        ray_ready = 1'b1;
        step();
        chk("after_done", {busy, done, ray_valid}, 0);
    endtask

    initial begin
        repeat (2) step();
        chk("reset_out", {busy, done, ray_valid, ray_last, ray_origin, ray_dir, ray_x, ray_y}, 0);
        rst_n = 1'b1;
        step();
        cp = '{-256, 256, -256}; cu = '{256, 0, 0}; cv = '{0, -256, 0}; cc = '{0, 0, 0};
        apply_cam();
        run_frame(2, 2, 0, 1'b0, 1'b1);
        chk("t1_first_dir", first_dir, {16'hFF00, 16'h0100, 16'hFF00});
        chk("t1_last_dir", last_dir, {16'hFF00, 16'h0000, 16'h0000});
        run_frame(2, 2, 1, 1'b0, 1'b0);
        img_w = '0;
        img_h = 12'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("zero_busy_done", {busy, done, ray_valid}, 3'b110);
        step();
        chk("zero_idle", {busy, done, ray_valid}, 0);
        seen = 1'b0;
        repeat (4) begin step(); seen |= ray_valid | busy | done; end
        chk("zero_quiet", ray_t'(seen), 0);
        rand_cam();
        run_frame(3, 3, 0, 1'b1, 1'b0);
        rand_cam();
        img_w = 12'd3;
        img_h = 12'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        step();
        chk("mid_reset", {busy, done, ray_valid, ray_last, ray_origin, ray_dir, ray_x, ray_y}, 0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin step(); seen |= ray_valid | busy | done; end
        chk("no_done_after_rst", ray_t'(seen), 0);
        run_frame(3, 3, 0, 1'b0, 1'b1);
        cp = '{0, 0, 0}; cu = '{32640, 0, 0}; cv = '{0, 0, 0}; cc = '{0, 0, 0};
        apply_cam();
        run_frame(4, 1, 0, 1'b0, 1'b0);
        chk("wrap_dir_x", ray_t'(last_dir[15:0]), 16'h7E80);
        repeat (6) begin
            rand_cam();
            run_frame(int'($urandom_range(1, 5)), int'($urandom_range(1, 4)), 2, 1'b0, 1'b0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
